// File: rtl/pio_byte_bridge.sv
// rtl/pio_byte_bridge.sv - host PIO byte bridge with TX/RX FIFOs and a byte presenter
module pio_byte_bridge #(
  parameter int TXD = 8,
  parameter int RXD = 4
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic [1:0] outsignal_export,
  input  logic [7:0] curbyteout_export,
  input  logic       load_export,
  output logic [7:0] curbytein_export,
  output logic       instrobe_export,
  output logic       empty_export,
  output logic       readytodownload_export,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic       overflow
);

  localparam int TAW = $clog2(TXD);
  localparam int RAW = $clog2(RXD);
  localparam logic [TAW:0] TX_FULL = (TAW + 1)'(TXD);
  localparam logic [RAW:0] RX_FULL = (RAW + 1)'(RXD);

  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_PUSH  = 2'b01,
    CMD_ACK   = 2'b10,
    CMD_FLUSH = 2'b11
  } cmd_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  // Host command capture
  logic       load_q;
  logic       load_armed;
  logic       cmd_valid;
  cmd_t       cmd_code;
  logic [7:0] cmd_byte;

  logic do_push;
  logic do_ack;
  logic do_flush;

  // TX FIFO (host -> fabric)
  logic [7:0]     tx_mem [TXD];
  logic [TAW-1:0] tx_wr_ptr;
  logic [TAW-1:0] tx_rd_ptr;
  logic [TAW:0]   tx_count;
  logic           tx_full;
  logic           tx_empty;
  logic           tx_wr;
  logic           tx_rd;

  // RX FIFO (fabric -> host)
  logic [7:0]     rx_mem [RXD];
  logic [RAW-1:0] rx_wr_ptr;
  logic [RAW-1:0] rx_rd_ptr;
  logic [RAW:0]   rx_count;
  logic           rx_full;
  logic           rx_empty;
  logic           rx_wr;
  logic           rx_pop;

  state_t state;

  // Register the load strobe and latch a command one cycle after its rising edge.
  // load_armed stays low after reset until load has been seen low, so a strobe
  // held high across reset release never looks like a fresh edge.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      load_q     <= 1'b0;
      load_armed <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd_code   <= CMD_NOP;
      cmd_byte   <= 8'h00;
    end else begin
      load_q     <= load_export;
      load_armed <= load_armed | ~load_export;
      cmd_valid  <= load_export & ~load_q & load_armed;
      cmd_code   <= cmd_t'(outsignal_export);
      cmd_byte   <= curbyteout_export;
    end
  end

  assign do_push  = cmd_valid && (cmd_code == CMD_PUSH);
  assign do_ack   = cmd_valid && (cmd_code == CMD_ACK);
  assign do_flush = cmd_valid && (cmd_code == CMD_FLUSH);

  assign tx_full  = (tx_count == TX_FULL);
  assign tx_empty = (tx_count == '0);
  // Fullness is judged before any pop in the same cycle.
  assign tx_wr    = do_push & ~tx_full;
  assign tx_rd    = ~tx_empty & tx_ready;

  assign tx_valid               = ~tx_empty;
  assign empty_export           = tx_empty;
  assign readytodownload_export = ~tx_full;
  assign tx_data                = tx_mem[tx_rd_ptr];

  // TX storage write; stale entries are harmless because occupancy gates reads
  always_ff @(posedge clk_clk) begin
    if (tx_wr) begin
      tx_mem[tx_wr_ptr] <= cmd_byte;
    end
  end

  // TX pointers, occupancy and sticky overflow; flush beats any fabric pop
  always_ff @(posedge clk_clk) begin
    if (reset_reset || do_flush) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
      overflow  <= 1'b0;
    end else begin
      if (tx_wr) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_rd) tx_rd_ptr <= tx_rd_ptr + 1'b1;
      tx_count <= tx_count + {{TAW{1'b0}}, tx_wr} - {{TAW{1'b0}}, tx_rd};
      if (do_push && tx_full) overflow <= 1'b1;
    end
  end

  assign rx_full  = (rx_count == RX_FULL);
  assign rx_empty = (rx_count == '0);
  assign rx_ready = ~rx_full;
  assign rx_wr    = rx_valid & ~rx_full;
  assign rx_pop   = (state == S_IDLE) & ~rx_empty;

  // RX storage write
  always_ff @(posedge clk_clk) begin
    if (rx_wr) begin
      rx_mem[rx_wr_ptr] <= rx_data;
    end
  end

  // RX pointers and occupancy; flush discards a same-cycle fabric write
  always_ff @(posedge clk_clk) begin
    if (reset_reset || do_flush) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_wr)  rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop) rx_rd_ptr <= rx_rd_ptr + 1'b1;
      rx_count <= rx_count + {{RAW{1'b0}}, rx_wr} - {{RAW{1'b0}}, rx_pop};
    end
  end

  // Presenter: hold one byte for the host until it is acknowledged
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state            <= S_IDLE;
      curbytein_export <= 8'h00;
      instrobe_export  <= 1'b0;
    end else if (do_flush) begin
      state           <= S_IDLE;
      instrobe_export <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!rx_empty) begin
            curbytein_export <= rx_mem[rx_rd_ptr];
            instrobe_export  <= 1'b1;
            state            <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (do_ack) begin
            instrobe_export <= 1'b0;
            state           <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pio_byte_bridge.sv
// tb/tb_pio_byte_bridge.sv - directed self-checking bench for pio_byte_bridge
module tb_pio_byte_bridge;

  logic       clk_clk = 1'b0;
  logic       reset_reset;
  logic [1:0] outsignal_export;
  logic [7:0] curbyteout_export;
  logic       load_export;
  logic [7:0] curbytein_export;
  logic       instrobe_export;
  logic       empty_export;
  logic       readytodownload_export;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       overflow;

  int passed = 0;
  int total  = 0;

  pio_byte_bridge #(.TXD(8), .RXD(4)) dut (
    .clk_clk                (clk_clk),
    .reset_reset            (reset_reset),
    .outsignal_export       (outsignal_export),
    .curbyteout_export      (curbyteout_export),
    .load_export            (load_export),
    .curbytein_export       (curbytein_export),
    .instrobe_export        (instrobe_export),
    .empty_export           (empty_export),
    .readytodownload_export (readytodownload_export),
    .tx_data                (tx_data),
    .tx_valid               (tx_valid),
    .tx_ready               (tx_ready),
    .rx_data                (rx_data),
    .rx_valid               (rx_valid),
    .rx_ready               (rx_ready),
    .overflow               (overflow)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Strobe load for one cycle; on return the command has taken effect.
  task automatic cmd(input logic [1:0] code, input logic [7:0] b);
    outsignal_export  = code;
    curbyteout_export = b;
    load_export       = 1'b1;
    tick();
    load_export       = 1'b0;
    tick();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_empty"},    32'(empty_export), 32'h1);
    chk({tag, "_rdy"},      32'(readytodownload_export), 32'h1);
    chk({tag, "_txvalid"},  32'(tx_valid), 32'h0);
    chk({tag, "_rxready"},  32'(rx_ready), 32'h1);
    chk({tag, "_instrobe"}, 32'(instrobe_export), 32'h0);
    chk({tag, "_curin"},    32'(curbytein_export), 32'h0);
    chk({tag, "_ovf"},      32'(overflow), 32'h0);
  endtask

  initial begin
    reset_reset       = 1'b1;
    outsignal_export  = 2'b01;
    curbyteout_export = 8'h99;
    load_export       = 1'b1;
    tx_ready          = 1'b0;
    rx_data           = 8'h00;
    rx_valid          = 1'b0;

    // Reset with load held high; release must not execute the PUSH
    tick();
    tick();
    check_reset_values("rst");
    reset_reset = 1'b0;
    tick();
    tick();
    tick();
    chk("rst_load_held_no_cmd", 32'(empty_export), 32'h1);
    load_export = 1'b0;
    tick();

    // Two pushes, then drain
    cmd(2'b01, 8'hA5);
    cmd(2'b01, 8'h3C);
    chk("push2_empty", 32'(empty_export), 32'h0);
    chk("push2_head", 32'(tx_data), 32'hA5);
    tx_ready = 1'b1;
    chk("drain_first", 32'(tx_data), 32'hA5);
    tick();
    chk("drain_second", 32'(tx_data), 32'h3C);
    chk("drain_second_valid", 32'(tx_valid), 32'h1);
    tick();
    chk("drain_done_empty", 32'(empty_export), 32'h1);
    chk("drain_done_valid", 32'(tx_valid), 32'h0);
    tx_ready = 1'b0;

    // Fill TX, overflow on the ninth, then flush
    for (int i = 0; i < 8; i++) begin
      cmd(2'b01, 8'(8'h10 + i));
      if (i == 6) chk("fill7_rdy", 32'(readytodownload_export), 32'h1);
    end
    chk("fill8_rdy", 32'(readytodownload_export), 32'h0);
    chk("fill8_ovf", 32'(overflow), 32'h0);
    cmd(2'b01, 8'hEE);
    chk("push9_ovf", 32'(overflow), 32'h1);
    chk("push9_head", 32'(tx_data), 32'h10);
    cmd(2'b00, 8'h00);
    chk("nop_ovf_kept", 32'(overflow), 32'h1);
    cmd(2'b11, 8'h00);
    chk("flush_ovf", 32'(overflow), 32'h0);
    chk("flush_empty", 32'(empty_export), 32'h1);
    chk("flush_rdy", 32'(readytodownload_export), 32'h1);

    // Load held high for 10 cycles queues exactly one byte
    outsignal_export  = 2'b01;
    curbyteout_export = 8'h7E;
    load_export       = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    load_export = 1'b0;
    tick();
    chk("held_load_head", 32'(tx_data), 32'h7E);
    tx_ready = 1'b1;
    tick();
    chk("held_load_one_byte", 32'(empty_export), 32'h1);
    tx_ready = 1'b0;

    // Fabric 11,22,33 presented in order with ACKs
    rx_valid = 1'b1;
    rx_data  = 8'h11;
    tick();
    rx_data  = 8'h22;
    tick();
    rx_data  = 8'h33;
    tick();
    rx_valid = 1'b0;
    chk("rx_first", 32'(curbytein_export), 32'h11);
    chk("rx_first_strobe", 32'(instrobe_export), 32'h1);
    cmd(2'b10, 8'h00);
    chk("ack_clears_strobe", 32'(instrobe_export), 32'h0);
    tick();
    chk("rx_second", 32'(curbytein_export), 32'h22);
    cmd(2'b10, 8'h00);
    tick();
    chk("rx_third", 32'(curbytein_export), 32'h33);
    cmd(2'b10, 8'h00);
    tick();
    chk("rx_done_strobe", 32'(instrobe_export), 32'h0);
    chk("rx_idle_retains", 32'(curbytein_export), 32'h33);
    cmd(2'b10, 8'h00);
    chk("ack_idle_ignored", 32'(instrobe_export), 32'h0);

    // Five fabric writes: four buffered plus one held, then all returned in order
    rx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rx_data = 8'(8'hA1 + i);
      tick();
    end
    rx_valid = 1'b0;
    chk("rx5_ready_low", 32'(rx_ready), 32'h0);
    chk("rx5_held", 32'(curbytein_export), 32'hA1);
    for (int i = 1; i < 5; i++) begin
      cmd(2'b10, 8'h00);
      tick();
      chk($sformatf("rx5_order%0d", i), 32'(curbytein_export), 32'(8'hA1 + i));
    end
    chk("rx5_ready_back", 32'(rx_ready), 32'h1);
    cmd(2'b10, 8'h00);
    tick();
    chk("rx5_drained", 32'(instrobe_export), 32'h0);

    // Flush drops a held byte but leaves the presented value
    rx_valid = 1'b1;
    rx_data  = 8'hD1;
    tick();
    rx_valid = 1'b0;
    tick();
    chk("pre_flush_strobe", 32'(instrobe_export), 32'h1);
    cmd(2'b11, 8'h00);
    chk("flush_strobe", 32'(instrobe_export), 32'h0);
    chk("flush_curin_kept", 32'(curbytein_export), 32'hD1);

    // Reset with 3 TX and 2 RX bytes buffered
    cmd(2'b01, 8'hB1);
    cmd(2'b01, 8'hB2);
    cmd(2'b01, 8'hB3);
    rx_valid = 1'b1;
    rx_data  = 8'hC1;
    tick();
    rx_data  = 8'hC2;
    tick();
    rx_valid = 1'b0;
    tick();
    chk("prerst_txvalid", 32'(tx_valid), 32'h1);
    chk("prerst_curin", 32'(curbytein_export), 32'hC1);
    reset_reset = 1'b1;
    tick();
    check_reset_values("midrst");
    reset_reset = 1'b0;
    tick();
    chk("postrst_txvalid", 32'(tx_valid), 32'h0);
    chk("postrst_instrobe", 32'(instrobe_export), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
